fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-domain controller for the async FIFO. It takes the raw Gray-coded write pointer from the write clock domain and runs it through an internal N-stage synchroniser. It maintains the read binary/Gray pointers and RAM read address, and produces registered empty, almost_empty, occupancy count and underflow flags. It sits between the read-side user logic, the dual-port RAM read port and the write-domain pointer logic.

Parameters:
ADDR_WIDTH, 6, RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
SYNC_STAGES, 2, flops in the wptr_gray synchroniser; legal range 2..4.
AE_THRESH, 4, almost_empty asserts when rd_count <= AE_THRESH; legal range 0..2**ADDR_WIDTH-1.

Ports:
clk  in  1  read-domain clock.
rst  in  1  synchronous, active-high reset.
rd_en  in  1  pop request.
wptr_gray  in  ADDR_WIDTH+1  Gray write pointer, asynchronous to clk.
clr_err  in  1  clears underflow_sticky.
rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, to the write domain.
raddr  out  ADDR_WIDTH  RAM read address = rbin[ADDR_WIDTH-1:0].
rd_fire  out  1  combinational rd_en && !empty; RAM read enable.
empty  out  1  registered empty flag.
almost_empty  out  1  registered almost-empty flag.
rd_count  out  ADDR_WIDTH+1  registered occupancy as seen from the read domain, 0..2**ADDR_WIDTH.
underflow  out  1  one-cycle pulse when rd_en && empty.
underflow_sticky  out  1  set by underflow, cleared by clr_err or rst.

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high, and sampled on posedge clk only.
- Reset values: rbin=0, rptr_gray=0, raddr=0, all synchroniser flops=0, empty=1, almost_empty=1, rd_count=0, underflow=0, underflow_sticky=0. rd_fire=0 follows from empty=1.
- Reset mid-operation: every state returns to its reset value on the next edge, and rd_en is ignored in that cycle.
- Synchroniser: wq = last stage of the SYNC_STAGES chain. No logic sits between the stages.
- Next pointer: rbin_next = rbin + rd_fire, computed modulo 2**(ADDR_WIDTH+1). Wrap from all-ones to 0 is natural; the MSB toggles each lap.
- rgray_next = rbin_next ^ (rbin_next >> 1). rptr_gray registers rgray_next.
- empty <= (rgray_next == wq). The full-width compare includes the MSB, so empty and full after a wrap are distinguished.
- wbin_sync = gray-to-binary(wq).
- rd_count <= (wbin_sync - rbin_next) modulo 2**(ADDR_WIDTH+1).
- almost_empty <= (that same difference <= AE_THRESH). It therefore always agrees with empty when the count is 0.
- Pop latency: rd_en high with empty=0 at edge N advances raddr at N+1. empty and rd_count at N+1 already reflect the pop.
- The RAM output for the old raddr is consumed by the user in cycle N. Read data timing is owned by the RAM wrapper, not this block.
- Write visibility: a wptr_gray change stable before edge N is visible in wq after edge N+SYNC_STAGES-1. empty/rd_count update at edge N+SYNC_STAGES.
- Flags are pessimistic: empty may stay high after a write, but it never deasserts while the FIFO is truly empty.
- Underflow: rd_en && empty means the pointer does not move. underflow pulses for exactly 1 cycle and underflow_sticky sets.
- Simultaneous clr_err and underflow: the set wins.
- Simultaneous pop and sync update in the same cycle: both are applied. rd_count = new wbin_sync - rbin_next.
- Continuous rd_en over empty: underflow pulses every cycle.

Decomposition:
- Package fifo_pkg holds:
  - function bin2gray / gray2bin, parameterised by width through a localparam in each user;
  - typedef ptr_t (logic [ADDR_WIDTH:0]), shared with the write-side controller.
- Sub-module gray_sync: SYNC_STAGES-deep flop chain with sync active-high reset. It is reused by the write-side controller for rptr.

Test Plan:
- Reset hold: rst=1 for 3 cycles with rd_en=1 and wptr_gray=5 -> empty=1, almost_empty=1, rd_count=0, raddr=0, underflow=0.
- Fill and drain (ADDR_WIDTH=3, AE_THRESH=2, SYNC_STAGES=2):
  - drive wptr_gray=gray(5)=7 -> empty falls 2 edges later, rd_count=5, almost_empty=0;
  - 3 pops -> rd_count 4,3,2, almost_empty=1 at count 2;
  - 2 more pops -> empty=1 and raddr=5.
- Wrap-around: step wptr through 0..15 while popping every cycle the FIFO is non-empty -> raddr wraps 7->0, rptr_gray MSB toggles at rbin=8, and the final rbin=15 read gives empty=1.
- Full occupancy: wptr binary=8 (gray 12), rbin=0 -> rd_count=8 and empty=0, i.e. MSB-distinguished full is not reported as empty.
- Underflow: rd_en=1 while empty for 2 cycles -> underflow pulses both cycles, sticky=1, raddr unchanged; clr_err=1 without rd_en -> sticky=0; clr_err with underflow in the same cycle -> sticky stays 1.
- Sync latency sweep, SYNC_STAGES=3: a single write step from empty -> empty deasserts exactly 3 edges after wptr_gray changes.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer type and Gray/binary conversions for the async FIFO read and write controllers.
package fifo_pkg;

  localparam int unsigned PTR_ADDR_W = 6;
  localparam int unsigned FN_W       = 32;

  typedef logic [PTR_ADDR_W:0] ptr_t;

  // Callers zero-extend to FN_W and truncate the result back to their own pointer width.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = int'(FN_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module gray_sync #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < int'(STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointers, RAM read address and registered status flags.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rd_fire,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow,
  output logic                  underflow_sticky
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_count;
  logic          r_underflow;
  logic          r_sticky;

  logic [PW-1:0] w_wq;
  logic [PW-1:0] w_wbin_sync;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_diff;
  logic          w_rd_fire;
  logic          w_underflow;

  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (wptr_gray),
    .o_q   (w_wq)
  );

  // Flags are computed against the post-pop pointer so they already reflect this cycle's read.
  assign w_rd_fire    = rd_en && !r_empty;
  assign w_underflow  = rd_en && r_empty;
  assign w_rbin_next  = r_rbin + PW'(w_rd_fire);
  assign w_rgray_next = PW'(bin2gray(FN_W'(w_rbin_next)));
  assign w_wbin_sync  = PW'(gray2bin(FN_W'(w_wq)));
  assign w_diff       = w_wbin_sync - w_rbin_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rbin         <= '0;
      r_rgray        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_count        <= '0;
      r_underflow    <= 1'b0;
      r_sticky       <= 1'b0;
    end else begin
      r_rbin         <= w_rbin_next;
      r_rgray        <= w_rgray_next;
      r_empty        <= (w_rgray_next == w_wq);
      r_almost_empty <= (w_diff <= PW'(AE_THRESH));
      r_count        <= w_diff;
      r_underflow    <= w_underflow;
      r_sticky       <= w_underflow || (r_sticky && !clr_err);
    end
  end

  assign rptr_gray        = r_rgray;
  assign raddr            = r_rbin[ADDR_WIDTH-1:0];
  assign rd_fire          = w_rd_fire;
  assign empty            = r_empty;
  assign almost_empty     = r_almost_empty;
  assign rd_count         = r_count;
  assign underflow        = r_underflow;
  assign underflow_sticky = r_sticky;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: vector table plus wrap-around and synchroniser-latency sequences.
module tb_fifo_rd_ctrl;

  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: ADDR_WIDTH=3, AE_THRESH=2, SYNC_STAGES=2
  logic          rst_a, rd_en_a, clr_a;
  logic [AW:0]   wptr_a, rptr_a, cnt_a;
  logic [AW-1:0] raddr_a;
  logic          fire_a, empty_a, ae_a, uf_a, st_a;

  // DUT B: same but SYNC_STAGES=3
  logic          rst_b, rd_en_b, clr_b;
  logic [AW:0]   wptr_b, rptr_b, cnt_b;
  logic [AW-1:0] raddr_b;
  logic          fire_b, empty_b, ae_b, uf_b, st_b;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .AE_THRESH(2)) dut_a (
    .clk(clk), .rst(rst_a), .rd_en(rd_en_a), .wptr_gray(wptr_a), .clr_err(clr_a),
    .rptr_gray(rptr_a), .raddr(raddr_a), .rd_fire(fire_a), .empty(empty_a),
    .almost_empty(ae_a), .rd_count(cnt_a), .underflow(uf_a), .underflow_sticky(st_a)
  );

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(3), .AE_THRESH(2)) dut_b (
    .clk(clk), .rst(rst_b), .rd_en(rd_en_b), .wptr_gray(wptr_b), .clr_err(clr_b),
    .rptr_gray(rptr_b), .raddr(raddr_b), .rd_fire(fire_b), .empty(empty_b),
    .almost_empty(ae_b), .rd_count(cnt_b), .underflow(uf_b), .underflow_sticky(st_b)
  );

  typedef struct {
    logic       rst;
    logic       rd_en;
    logic       clr;
    logic [3:0] wptr;
    logic       e;
    logic       ae;
    logic [3:0] cnt;
    logic [2:0] raddr;
    logic [3:0] rgray;
    logic       uf;
    logic       st;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic add(input logic rst, input logic rd, input logic clr, input logic [3:0] wp,
                     input logic e, input logic ae, input logic [3:0] cnt, input logic [2:0] ra,
                     input logic [3:0] rg, input logic uf, input logic st);
    vec_t v;
    v.rst = rst; v.rd_en = rd; v.clr = clr; v.wptr = wp;
    v.e = e; v.ae = ae; v.cnt = cnt; v.raddr = ra; v.rgray = rg; v.uf = uf; v.st = st;
    vq.push_back(v);
  endtask

  // Wrap-around model state (binary pointers, SYNC_STAGES=2)
  logic [3:0] m_s0, m_s1, m_rbin, m_cnt;
  logic       m_e, m_fire;
  logic [2:0] prev_raddr;
  int         wbin, edges;
  bit         seen_wrap, done, prev_e;

  initial begin
    rst_a = 1'b1; rd_en_a = 1'b0; clr_a = 1'b0; wptr_a = 4'd0;
    rst_b = 1'b1; rd_en_b = 1'b0; clr_b = 1'b0; wptr_b = 4'd0;

    //   rst   rd    clr   wptr   | e     ae    cnt   raddr rgray uf    st
    add(1'b1, 1'b1, 1'b0, 4'd5,  1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'd5,  1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'd5,  1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd7,  1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd7,  1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd7,  1'b0, 1'b0, 4'd5, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 4'd4, 3'd1, 4'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 4'd3, 3'd2, 4'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 4'd2, 3'd3, 4'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 4'd1, 3'd4, 4'd6, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd7,  1'b1, 1'b1, 4'd0, 3'd5, 4'd7, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd7,  1'b1, 1'b1, 4'd0, 3'd5, 4'd7, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'd7,  1'b1, 1'b1, 4'd0, 3'd5, 4'd7, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'd7,  1'b1, 1'b1, 4'd0, 3'd5, 4'd7, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'd7,  1'b1, 1'b1, 4'd0, 3'd5, 4'd7, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'd7,  1'b1, 1'b1, 4'd0, 3'd5, 4'd7, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'd7,  1'b1, 1'b1, 4'd0, 3'd5, 4'd7, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 4'd8, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 4'd8, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 4'd8, 3'd0, 4'd0, 1'b0, 1'b0);

    // Table: inputs applied before an edge, registered outputs checked after it
    prev_e = 1'b1;
    foreach (vq[i]) begin
      rst_a = vq[i].rst; rd_en_a = vq[i].rd_en; clr_a = vq[i].clr; wptr_a = vq[i].wptr;
      #1;
      if (i > 0) chk($sformatf("v%0d_rd_fire", i), int'(fire_a), int'(vq[i].rd_en && !prev_e));
      tick();
      chk($sformatf("v%0d_empty", i),        int'(empty_a), int'(vq[i].e));
      chk($sformatf("v%0d_almost_empty", i), int'(ae_a),    int'(vq[i].ae));
      chk($sformatf("v%0d_rd_count", i),     int'(cnt_a),   int'(vq[i].cnt));
      chk($sformatf("v%0d_raddr", i),        int'(raddr_a), int'(vq[i].raddr));
      chk($sformatf("v%0d_rptr_gray", i),    int'(rptr_a),  int'(vq[i].rgray));
      chk($sformatf("v%0d_underflow", i),    int'(uf_a),    int'(vq[i].uf));
      chk($sformatf("v%0d_sticky", i),       int'(st_a),    int'(vq[i].st));
      prev_e = vq[i].e;
    end

    // Wrap-around: write pointer steps 0..15, pop whenever non-empty
    rst_a = 1'b1; rd_en_a = 1'b0; clr_a = 1'b0; wptr_a = 4'd0;
    tick(); tick();
    rst_a = 1'b0;
    m_s0 = 4'd0; m_s1 = 4'd0; m_rbin = 4'd0; m_e = 1'b1;
    wbin = 0; prev_raddr = 3'd0; seen_wrap = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (wbin < 15 && (wbin - int'(m_rbin)) < 8) wbin++;
      wptr_a  = gray4(4'(wbin));
      rd_en_a = !m_e;
      m_fire  = rd_en_a && !m_e;
      #1;
      chk("wrap_rd_fire", int'(fire_a), int'(m_fire));
      tick();
      m_rbin = m_rbin + 4'(m_fire);
      m_e    = (m_s1 == m_rbin);
      m_cnt  = m_s1 - m_rbin;
      m_s1   = m_s0;
      m_s0   = 4'(wbin);
      chk("wrap_raddr",     int'(raddr_a), int'(m_rbin[2:0]));
      chk("wrap_empty",     int'(empty_a), int'(m_e));
      chk("wrap_rd_count",  int'(cnt_a),   int'(m_cnt));
      chk("wrap_rptr_gray", int'(rptr_a),  int'(gray4(m_rbin)));
      if (prev_raddr == 3'd7 && raddr_a == 3'd0) seen_wrap = 1'b1;
      prev_raddr = raddr_a;
      if (wbin == 15 && m_rbin == 4'd15 && m_e) done = 1'b1;
    end
    rd_en_a = 1'b0;
    chk("wrap_completed",  int'(done),      1);
    chk("wrap_raddr_7to0", int'(seen_wrap), 1);
    chk("wrap_final_rptr", int'(rptr_a),    8);
    chk("wrap_final_empty", int'(empty_a),  1);

    // Synchroniser latency with SYNC_STAGES=3: count edges after the first sampling edge
    rst_b = 1'b1; wptr_b = 4'd0;
    tick(); tick();
    rst_b = 1'b0;
    tick();
    chk("lat_empty_before", int'(empty_b), 1);
    wptr_b = 4'd1;
    tick();
    edges = 0;
    while (empty_b && edges < 10) begin
      tick();
      edges++;
    end
    chk("lat_edges",    edges,        3);
    chk("lat_rd_count", int'(cnt_b),  1);
    chk("lat_almost",   int'(ae_b),   1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
